mem_bus_arbiter: RTL and testbench
==================================

# mem_bus_arbiter

Two-port arbiter that shares the single-port `memory_integrated` bus between the CPU load/store/fetch path (port 0) and a second master, the program loader/debug port (port 1). It serialises accesses through a three-state access FSM. It drives the memory's address, write data and write enable, and returns read data with a valid pulse to the winning master. Fairness between the ports is round-robin or fixed-priority, selected at compile time.

## Interface
Parameters:
- `ADDR_W`, 32, address width of both masters and the memory side.
- `DATA_W`, 32, data width.

Ports:
- `clk` in 1: system clock (PLL output).
- `rst` in 1: reset, asynchronous, active-low.
- `req0` / `req1` in 1: access request, level, held until grant.
- `we0` / `we1` in 1: 1 = write, 0 = read; qualified by req.
- `addr0` / `addr1` in ADDR_W: byte address.
- `wdata0` / `wdata1` in DATA_W: write data.
- `gnt0` / `gnt1` out 1: one-cycle grant pulse; request accepted.
- `rvalid0` / `rvalid1` out 1: one-cycle completion pulse; carries read data for reads, acts as write acknowledge for writes.
- `rdata0` / `rdata1` out DATA_W: read data, valid while the matching rvalid is high, zero otherwise.
- `mem_addr` out ADDR_W: memory address.
- `mem_wdata` out DATA_W: memory write data.
- `mem_we` out 1: memory write enable.
- `mem_rdata` in DATA_W: memory read data, registered, valid the cycle after the address is presented.
- `busy` out 1: high whenever the FSM is not in IDLE.

## Operation
- States are IDLE, ACCESS and RESP. IDLE goes to ACCESS if any req is high, otherwise stays in IDLE. ACCESS always goes to RESP. RESP always goes to IDLE.
- Arbitration is evaluated only in IDLE, combinationally from req0/req1.
  - Single requester: that port wins.
  - Both requesting: the winner is set by the configuration (see Configuration).
- On the IDLE→ACCESS edge the arbiter:
  - registers the winner's addr into mem_addr, with bits [1:0] forced to 0 (word-aligned);
  - registers the winner's wdata into mem_wdata;
  - registers winner `we` into mem_we and the winner index into `owner`;
  - sets gnt_owner = 1.
- ACCESS:
  - gnt_owner is high for exactly this cycle.
  - mem_we = latched we; memory samples at the end of ACCESS.
  - The master must drop req at the end of the gnt cycle, or keep it high only to issue a new request.
- RESP:
  - mem_we = 0; rvalid_owner = 1.
  - rdata_owner = mem_rdata. For writes the rdata value is don't-care but still driven from mem_rdata.
  - The non-owner's rvalid/rdata stay 0.
- mem_addr and mem_wdata hold their last value outside ACCESS. mem_we is high only in ACCESS of a write.
- Requests raised during ACCESS or RESP wait; they are arbitrated in the next IDLE.
- Reset values: state = IDLE, gnt0 = gnt1 = 0, rvalid0 = rvalid1 = 0, rdata = 0, mem_addr = 0, mem_wdata = 0, mem_we = 0, busy = 0, last_grant = 1, owner = 0.
- Reset mid-transaction: the access is abandoned immediately and asynchronously. mem_we drops at once, no rvalid is issued, and the master must re-request after reset.

## Timing
- Request to gnt: 1 clock. The req edge is seen in IDLE cycle T; gnt is high in T+1.
- gnt to rvalid: 1 clock (rvalid in T+2).
- Back-to-back throughput: one access per 3 clocks. The next IDLE is T+3, the next gnt is T+4.
- All outputs are registered or decoded from state registers. The only combinational path from an input to an output is rdata_x from mem_rdata during RESP.

## Configuration
- `MEM_ARB_RR_EN` defined: round-robin.
  - On simultaneous requests the winner is the port not equal to last_grant.
  - last_grant updates on every grant.
  - Port 0 wins the first tie after reset (last_grant resets to 1).
- `MEM_ARB_RR_EN` undefined: fixed priority, and port 0 always wins ties.
  - last_grant is not implemented.
  - Port 1 may starve while port 0 requests continuously. This is accepted behaviour.

## Test plan
- Single read: req0 = 1, we0 = 0, addr0 = 0x0000_0013, memory word at 0x10 = 0xDEAD_BEEF.
  - Required: gnt0 at T+1 with mem_addr = 0x0000_0010 and mem_we = 0; rvalid0 at T+2 with rdata0 = 0xDEAD_BEEF; rvalid1 = 0 throughout.
- Single write from port 1: req1 = 1, we1 = 1, addr1 = 0x20, wdata1 = 0x1234_5678.
  - Required: mem_we = 1 for exactly one cycle (T+1); rvalid1 at T+2.
  - A follow-up port 0 read of 0x20 returns 0x1234_5678.
- Contention with RR enabled: req0 and req1 held high for 4 accesses.
  - Required: grant order 0, 1, 0, 1; gnts at T+1, T+4, T+7, T+10.
- Contention with `MEM_ARB_RR_EN` undefined and the same stimulus.
  - Required: all 4 grants go to port 0; gnt1 never asserts while req0 = 1.
- Late request: req1 rises during port 0's ACCESS cycle.
  - Required: port 0 completes unaffected; port 1 is granted in the first cycle after the next IDLE.
- Reset in ACCESS of a write: assert rst = 0 mid-cycle.
  - Required: mem_we, gnt and busy go to 0 immediately; no rvalid is issued.
  - After release, state is IDLE and a new req0 is granted in 1 clock.

Source files
------------

// File: rtl/mem_bus_arbiter_if.sv
// +-----------------------------------------------------------------------------+
// | mem_bus_arbiter_if                                                          |
// | Two-master request/grant bus plus single-port memory side for the arbiter.  |
// | Rev 1.0 - initial release                                                   |
// +-----------------------------------------------------------------------------+
`default_nettype none

interface mem_bus_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              req0;
    logic              req1;
    logic              we0;
    logic              we1;
    logic [ADDR_W-1:0] addr0;
    logic [ADDR_W-1:0] addr1;
    logic [DATA_W-1:0] wdata0;
    logic [DATA_W-1:0] wdata1;
    logic              gnt0;
    logic              gnt1;
    logic              rvalid0;
    logic              rvalid1;
    logic [DATA_W-1:0] rdata0;
    logic [DATA_W-1:0] rdata1;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_we;
    logic [DATA_W-1:0] mem_rdata;
    logic              busy;

    // Arbiter view
    modport slave (
        input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_rdata,
        output gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1,
               mem_addr, mem_wdata, mem_we, busy
    );

    // Masters and memory view
    modport master (
        output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_rdata,
        input  gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1,
               mem_addr, mem_wdata, mem_we, busy
    );
endinterface

`default_nettype wire

// File: rtl/mem_bus_arbiter.sv
// +-----------------------------------------------------------------------------+
// | mem_bus_arbiter                                                             |
// | Serialises two masters onto one memory port via IDLE/ACCESS/RESP FSM.       |
// | Define MEM_ARB_RR_EN for round-robin ties; otherwise port 0 has priority.   |
// | Rev 1.0 - initial release                                                   |
// +-----------------------------------------------------------------------------+
`default_nettype none

module mem_bus_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  wire logic        clk,
    input  wire logic        rst,
    mem_bus_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_RESP   = 2'd2
    } state_t;

    localparam logic [ADDR_W-1:0] c_align_mask = ~ADDR_W'(3);

    state_t            r_state;
    state_t            w_state_nxt;
    logic              r_owner;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic              w_any_req;
    logic              w_winner;
    logic              w_tie_winner;
    logic              w_start;

    assign w_any_req = bus.req0 | bus.req1;
    assign w_start   = (r_state == S_IDLE) && w_any_req;

`ifdef MEM_ARB_RR_EN
    logic r_last_grant;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_last_grant <= 1'b1;
        end else if (w_start) begin
            r_last_grant <= w_winner;
        end
    end

    assign w_tie_winner = ~r_last_grant;
`else
    assign w_tie_winner = 1'b0;
`endif

    // Port 1 wins when it is the sole requester, or on a tie the policy favours it
    assign w_winner = bus.req1 & (~bus.req0 | w_tie_winner);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:   w_state_nxt = w_any_req ? S_ACCESS : S_IDLE;
            S_ACCESS: w_state_nxt = S_RESP;
            S_RESP:   w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_owner <= 1'b0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
        end else if (w_start) begin
            r_owner <= w_winner;
            r_we    <= w_winner ? bus.we1 : bus.we0;
            r_addr  <= (w_winner ? bus.addr1 : bus.addr0) & c_align_mask;
            r_wdata <= w_winner ? bus.wdata1 : bus.wdata0;
        end
    end

    // All handshake outputs decode from state; only rdata passes mem_rdata through
    assign bus.gnt0      = (r_state == S_ACCESS) && !r_owner;
    assign bus.gnt1      = (r_state == S_ACCESS) &&  r_owner;
    assign bus.rvalid0   = (r_state == S_RESP)   && !r_owner;
    assign bus.rvalid1   = (r_state == S_RESP)   &&  r_owner;
    assign bus.rdata0    = bus.rvalid0 ? bus.mem_rdata : '0;
    assign bus.rdata1    = bus.rvalid1 ? bus.mem_rdata : '0;
    assign bus.mem_we    = (r_state == S_ACCESS) && r_we;
    assign bus.mem_addr  = r_addr;
    assign bus.mem_wdata = r_wdata;
    assign bus.busy      = (r_state != S_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_mem_bus_arbiter.sv
// +-----------------------------------------------------------------------------+
// | tb_mem_bus_arbiter                                                          |
// | Self-checking bench: directed scenarios plus randomized traffic vs model.   |
// | Rev 1.0 - initial release                                                   |
// +-----------------------------------------------------------------------------+
`default_nettype none

module tb_mem_bus_arbiter;

    logic clk;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    mem_bus_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    mem_bus_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory stand-in: registered read, write on the edge ending ACCESS
    logic [31:0] ram [0:255];
    logic        bd_clr;
    logic        bd_we;
    logic [7:0]  bd_idx;
    logic [31:0] bd_data;

    always @(posedge clk) begin
        if (bd_clr) begin
            for (int i = 0; i < 256; i++) ram[i] <= 32'h0;
        end else if (bd_we) begin
            ram[bd_idx] <= bd_data;
        end else if (bus.mem_we) begin
            ram[bus.mem_addr[9:2]] <= bus.mem_wdata;
        end
        bus.mem_rdata <= ram[bus.mem_addr[9:2]];
    end

    // Reference model: word store plus last-winner record
    logic [31:0] ref_mem [int];
    bit          model_last;

    function automatic logic [31:0] ref_read(input logic [31:0] a);
        int idx;
        idx = int'(a[9:2]);
        return ref_mem.exists(idx) ? ref_mem[idx] : 32'h0;
    endfunction

    function automatic bit model_winner(input bit r0, input bit r1);
        if (r0 && r1) begin
`ifdef MEM_ARB_RR_EN
            return !model_last;
`else
            return 1'b0;
`endif
        end
        return r1;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input bit r0, input bit r1, input bit w0, input bit w1,
                         input logic [31:0] a0, input logic [31:0] a1,
                         input logic [31:0] d0, input logic [31:0] d1);
        bus.req0 = r0;     bus.req1 = r1;
        bus.we0 = w0;      bus.we1 = w1;
        bus.addr0 = a0;    bus.addr1 = a1;
        bus.wdata0 = d0;   bus.wdata1 = d1;
    endtask

    task automatic test_reset();
        rst = 1'b0; bd_clr = 1'b1; bd_we = 1'b0; bd_idx = 8'h0; bd_data = 32'h0;
        issue(0, 0, 0, 0, 0, 0, 0, 0);
        model_last = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++; if ({bus.gnt0, bus.gnt1, bus.rvalid0, bus.rvalid1} !== 4'b0000) begin
            errors++; $display("FAIL rst_hs: got %b expected 0000", {bus.gnt0, bus.gnt1, bus.rvalid0, bus.rvalid1}); end
        checks++; if ({bus.rdata0, bus.rdata1} !== 64'h0) begin
            errors++; $display("FAIL rst_rdata: got %h expected 0", {bus.rdata0, bus.rdata1}); end
        checks++; if ({bus.mem_addr, bus.mem_wdata} !== 64'h0) begin
            errors++; $display("FAIL rst_mem: got %h expected 0", {bus.mem_addr, bus.mem_wdata}); end
        checks++; if ({bus.mem_we, bus.busy} !== 2'b00) begin
            errors++; $display("FAIL rst_we_busy: got %b expected 00", {bus.mem_we, bus.busy}); end
        bd_clr = 1'b0;
        rst = 1'b1;
        tick();
        checks++; if ({bus.busy, bus.gnt0, bus.gnt1} !== 3'b000) begin
            errors++; $display("FAIL rst_idle: got %b expected 000", {bus.busy, bus.gnt0, bus.gnt1}); end
    endtask

    task automatic test_contention();
        bit exp_w;
        logic [1:0] exp_g;
        issue(1, 1, 0, 0, 32'h0, 32'h4, 0, 0);
        for (int c = 1; c <= 12; c++) begin
            tick();
            exp_g = 2'b00;
            if (c == 1 || c == 4 || c == 7 || c == 10) begin
                exp_w = model_winner(1'b1, 1'b1);
                model_last = exp_w;
                exp_g = exp_w ? 2'b10 : 2'b01;
            end
            checks++; if ({bus.gnt1, bus.gnt0} !== exp_g) begin
                errors++; $display("FAIL cont_gnt c=%0d: got %b expected %b", c, {bus.gnt1, bus.gnt0}, exp_g); end
            if (c == 10) issue(0, 0, 0, 0, 0, 0, 0, 0);
        end
    endtask

    task automatic test_single_read();
        bd_we = 1'b1; bd_idx = 8'h04; bd_data = 32'hDEAD_BEEF;
        ref_mem[4] = 32'hDEAD_BEEF;
        tick();
        bd_we = 1'b0;
        issue(1, 0, 0, 0, 32'h13, 0, 0, 0);
        tick();
        model_last = 1'b0;
        checks++; if ({bus.gnt0, bus.gnt1, bus.mem_we, bus.busy} !== 4'b1001) begin
            errors++; $display("FAIL rd_gnt: got %b expected 1001", {bus.gnt0, bus.gnt1, bus.mem_we, bus.busy}); end
        checks++; if (bus.mem_addr !== 32'h10) begin
            errors++; $display("FAIL rd_addr: got %h expected 00000010", bus.mem_addr); end
        bus.req0 = 1'b0;
        tick();
        checks++; if ({bus.rvalid0, bus.rvalid1, bus.gnt0} !== 3'b100) begin
            errors++; $display("FAIL rd_rvalid: got %b expected 100", {bus.rvalid0, bus.rvalid1, bus.gnt0}); end
        checks++; if (bus.rdata0 !== ref_read(32'h10) || bus.rdata1 !== 32'h0) begin
            errors++; $display("FAIL rd_data: got %h/%h expected %h/0", bus.rdata0, bus.rdata1, ref_read(32'h10)); end
        tick();
        checks++; if ({bus.rvalid0, bus.busy} !== 2'b00) begin
            errors++; $display("FAIL rd_end: got %b expected 00", {bus.rvalid0, bus.busy}); end
    endtask

    task automatic test_single_write();
        issue(0, 1, 0, 1, 0, 32'h20, 0, 32'h1234_5678);
        tick();
        model_last = 1'b1;
        checks++; if ({bus.gnt1, bus.gnt0, bus.mem_we} !== 3'b101) begin
            errors++; $display("FAIL wr_gnt: got %b expected 101", {bus.gnt1, bus.gnt0, bus.mem_we}); end
        checks++; if (bus.mem_addr !== 32'h20 || bus.mem_wdata !== 32'h1234_5678) begin
            errors++; $display("FAIL wr_bus: got %h/%h expected 00000020/12345678", bus.mem_addr, bus.mem_wdata); end
        bus.req1 = 1'b0;
        ref_mem[8] = 32'h1234_5678;
        tick();
        checks++; if ({bus.mem_we, bus.rvalid1, bus.rvalid0} !== 3'b010) begin
            errors++; $display("FAIL wr_resp: got %b expected 010", {bus.mem_we, bus.rvalid1, bus.rvalid0}); end
        tick();
        issue(1, 0, 0, 0, 32'h20, 0, 0, 0);
        tick();
        model_last = 1'b0;
        checks++; if (bus.gnt0 !== 1'b1) begin
            errors++; $display("FAIL wr_rb_gnt: got %b expected 1", bus.gnt0); end
        bus.req0 = 1'b0;
        tick();
        checks++; if (bus.rvalid0 !== 1'b1 || bus.rdata0 !== 32'h1234_5678) begin
            errors++; $display("FAIL wr_rb_data: got %b/%h expected 1/12345678", bus.rvalid0, bus.rdata0); end
        tick();
    endtask

    task automatic test_late_request();
        issue(1, 0, 0, 0, 32'h8, 0, 0, 0);
        tick();
        model_last = 1'b0;
        checks++; if (bus.gnt0 !== 1'b1) begin
            errors++; $display("FAIL late_gnt0: got %b expected 1", bus.gnt0); end
        issue(0, 1, 0, 0, 32'h8, 32'hC, 0, 0);
        tick();
        checks++; if ({bus.rvalid0, bus.rvalid1, bus.gnt1} !== 3'b100 || bus.rdata0 !== ref_read(32'h8)) begin
            errors++; $display("FAIL late_resp0: got %b/%h expected 100/%h", {bus.rvalid0, bus.rvalid1, bus.gnt1}, bus.rdata0, ref_read(32'h8)); end
        tick();
        checks++; if ({bus.gnt1, bus.busy} !== 2'b00) begin
            errors++; $display("FAIL late_idle: got %b expected 00", {bus.gnt1, bus.busy}); end
        tick();
        model_last = 1'b1;
        checks++; if ({bus.gnt1, bus.gnt0} !== 2'b10) begin
            errors++; $display("FAIL late_gnt1: got %b expected 10", {bus.gnt1, bus.gnt0}); end
        bus.req1 = 1'b0;
        tick();
        checks++; if (bus.rvalid1 !== 1'b1 || bus.rdata1 !== ref_read(32'hC)) begin
            errors++; $display("FAIL late_resp1: got %b/%h expected 1/%h", bus.rvalid1, bus.rdata1, ref_read(32'hC)); end
        tick();
    endtask

    task automatic test_random();
        bit          r0, r1, w0, w1, win, exp_we;
        logic [31:0] a0, a1, d0, d1, exp_a, exp_d;
        for (int n = 0; n < 40; n++) begin
            r0 = 1'($urandom_range(0, 1));
            r1 = 1'($urandom_range(0, 1));
            if (!r0 && !r1) r0 = 1'b1;
            w0 = 1'($urandom_range(0, 1));
            w1 = 1'($urandom_range(0, 1));
            a0 = 32'($urandom_range(0, 255));
            a1 = 32'($urandom_range(0, 255));
            d0 = $urandom;
            d1 = $urandom;
            issue(r0, r1, w0, w1, a0, a1, d0, d1);
            win = model_winner(r0, r1);
            model_last = win;
            exp_a  = (win ? a1 : a0) & 32'hFFFF_FFFC;
            exp_we = win ? w1 : w0;
            exp_d  = win ? d1 : d0;
            tick();
            checks++; if ({bus.gnt1, bus.gnt0} !== (win ? 2'b10 : 2'b01)) begin
                errors++; $display("FAIL rnd_gnt n=%0d: got %b expected winner %0d", n, {bus.gnt1, bus.gnt0}, win); end
            checks++; if (bus.mem_addr !== exp_a || bus.mem_we !== exp_we) begin
                errors++; $display("FAIL rnd_bus n=%0d: got %h/%b expected %h/%b", n, bus.mem_addr, bus.mem_we, exp_a, exp_we); end
            if (exp_we) begin
                checks++; if (bus.mem_wdata !== exp_d) begin
                    errors++; $display("FAIL rnd_wdata n=%0d: got %h expected %h", n, bus.mem_wdata, exp_d); end
            end
            issue(0, 0, 0, 0, 0, 0, 0, 0);
            tick();
            checks++; if ({bus.rvalid1, bus.rvalid0, bus.mem_we} !== (win ? 3'b100 : 3'b010)) begin
                errors++; $display("FAIL rnd_rvalid n=%0d: got %b expected winner %0d", n, {bus.rvalid1, bus.rvalid0, bus.mem_we}, win); end
            if (!exp_we) begin
                checks++; if ((win ? bus.rdata1 : bus.rdata0) !== ref_read(exp_a) || (win ? bus.rdata0 : bus.rdata1) !== 32'h0) begin
                    errors++; $display("FAIL rnd_rdata n=%0d: got %h/%h expected %h on port %0d", n, bus.rdata0, bus.rdata1, ref_read(exp_a), win); end
            end else begin
                ref_mem[int'(exp_a[9:2])] = exp_d;
            end
            tick();
            checks++; if (bus.busy !== 1'b0) begin
                errors++; $display("FAIL rnd_idle n=%0d: got %b expected 0", n, bus.busy); end
        end
    endtask

    task automatic test_reset_in_access();
        issue(1, 0, 1, 0, 32'h40, 0, 32'hCAFE_F00D, 0);
        tick();
        checks++; if ({bus.gnt0, bus.mem_we} !== 2'b11) begin
            errors++; $display("FAIL ra_access: got %b expected 11", {bus.gnt0, bus.mem_we}); end
        #2;
        rst = 1'b0;
        model_last = 1'b1;
        #1;
        checks++; if ({bus.mem_we, bus.gnt0, bus.gnt1, bus.busy} !== 4'b0000) begin
            errors++; $display("FAIL ra_async: got %b expected 0000", {bus.mem_we, bus.gnt0, bus.gnt1, bus.busy}); end
        bus.req0 = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tick();
            checks++; if ({bus.rvalid0, bus.rvalid1} !== 2'b00) begin
                errors++; $display("FAIL ra_no_rvalid c=%0d: got %b expected 00", c, {bus.rvalid0, bus.rvalid1}); end
        end
        rst = 1'b1;
        issue(1, 0, 0, 0, 32'h40, 0, 0, 0);
        tick();
        model_last = 1'b0;
        checks++; if ({bus.gnt0, bus.busy} !== 2'b11) begin
            errors++; $display("FAIL ra_regrant: got %b expected 11", {bus.gnt0, bus.busy}); end
        bus.req0 = 1'b0;
        tick();
        checks++; if (bus.rvalid0 !== 1'b1 || bus.rdata0 !== ref_read(32'h40)) begin
            errors++; $display("FAIL ra_unwritten: got %b/%h expected 1/%h", bus.rvalid0, bus.rdata0, ref_read(32'h40)); end
        tick();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_contention();
        test_single_read();
        test_single_write();
        test_late_request();
        test_random();
        test_reset_in_access();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
